// File: rtl/encoder_4to2.sv
// encoder_4to2 : 4-input priority encoder with a combinational result and a
// registered copy of it.
//
// Parameters:
//   PRIORITY_HIGH  1 = highest index wins (D3 > D2 > D1 > D0)
//                  0 = lowest index wins  (D0 > D1 > D2 > D3)
//
// Ports:
//   clk        in   single clock, rising-edge
//   rst        in   asynchronous active-high reset
//   D0..D3     in   request lines
//   Y[1:0]     out  combinational index of the winning request
//   V          out  combinational valid (any request active)
//   Y_q[1:0]   out  Y registered on clk
//   V_q        out  V registered on clk
//   CHG        out  one-cycle pulse when the registered {V_q,Y_q} changed
//   M          out  sticky multi-hot flag (optional feature)
//
// Build option:
//   ENCODER_4TO2_MULTI_HOT_EN  when defined, M is a sticky flag set on any
//   edge that sees two or more requests at once and cleared only by rst.
//   When undefined, M is tied to 0 and no multi-hot logic exists.
//
// Y is 00 both for "D0 wins" and for "no request"; consumers qualify with V.

module encoder_4to2 #(
    parameter int PRIORITY_HIGH = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       D0,
    input  logic       D1,
    input  logic       D2,
    input  logic       D3,
    output logic [1:0] Y,
    output logic       V,
    output logic [1:0] Y_q,
    output logic       V_q,
    output logic       CHG,
    output logic       M
);

    logic [1:0] y_c;
    logic       v_c;

    always_comb begin
        y_c = 2'b00;
        if (PRIORITY_HIGH != 0) begin
            if (D3)      y_c = 2'b11;
            else if (D2) y_c = 2'b10;
            else if (D1) y_c = 2'b01;
            else         y_c = 2'b00;
        end else begin
            // No request falls through to 00 rather than 11.
            if (D0)      y_c = 2'b00;
            else if (D1) y_c = 2'b01;
            else if (D2) y_c = 2'b10;
            else if (D3) y_c = 2'b11;
            else         y_c = 2'b00;
        end
    end

    assign v_c = D0 | D1 | D2 | D3;
    assign Y   = y_c;
    assign V   = v_c;

    // CHG compares the value being captured against the value currently held,
    // so it is high during the cycle following a change of the registered copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Y_q <= 2'b00;
            V_q <= 1'b0;
            CHG <= 1'b0;
        end else begin
            Y_q <= y_c;
            V_q <= v_c;
            CHG <= ({v_c, y_c} != {V_q, Y_q});
        end
    end

`ifdef ENCODER_4TO2_MULTI_HOT_EN
    logic [2:0] req_count;
    logic       multi_sticky;

    assign req_count = {2'b00, D0} + {2'b00, D1} + {2'b00, D2} + {2'b00, D3};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            multi_sticky <= 1'b0;
        end else if (req_count >= 3'd2) begin
            multi_sticky <= 1'b1;
        end
    end

    assign M = multi_sticky;
`else
    assign M = 1'b0;
`endif

endmodule

// File: tb/tb_encoder_4to2.sv
module tb_encoder_4to2;

    logic       clk;
    logic       rst;
    logic [3:0] d;

    logic [1:0] y_hi, yq_hi, y_lo, yq_lo;
    logic       v_hi, vq_hi, chg_hi, m_hi;
    logic       v_lo, vq_lo, chg_lo, m_lo;

    int tests;
    int fails;

`ifdef ENCODER_4TO2_MULTI_HOT_EN
    localparam bit MH_EN = 1'b1;
`else
    localparam bit MH_EN = 1'b0;
`endif

    // Expected Y for d = 0..15, hand-derived from the priority rules.
    logic [1:0] exp_hi [16] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2,
                                2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    logic [1:0] exp_lo [16] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0,
                                2'd3, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0};
    logic       exp_multi [16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
                                   1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    encoder_4to2 #(.PRIORITY_HIGH(1)) dut_hi (
        .clk(clk), .rst(rst),
        .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
        .Y(y_hi), .V(v_hi), .Y_q(yq_hi), .V_q(vq_hi), .CHG(chg_hi), .M(m_hi)
    );

    encoder_4to2 #(.PRIORITY_HIGH(0)) dut_lo (
        .clk(clk), .rst(rst),
        .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
        .Y(y_lo), .V(v_lo), .Y_q(yq_lo), .V_q(vq_lo), .CHG(chg_lo), .M(m_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step_drive(input logic [3:0] val);
        @(negedge clk);
        d = val;
        #1;
    endtask

    task automatic step_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] prev_hi, prev_lo, cur_hi, cur_lo;
        logic       sticky;

        tests = 0;
        fails = 0;
        rst   = 1'b1;
        d     = 4'b0000;

        // Reset state
        #12;
        check("rst_yq_hi",  {2'b0, yq_hi},  4'h0);
        check("rst_vq_hi",  {3'b0, vq_hi},  4'h0);
        check("rst_chg_hi", {3'b0, chg_hi}, 4'h0);
        check("rst_m_hi",   {3'b0, m_hi},   4'h0);
        @(negedge clk);
        rst = 1'b0;

        // 0000
        step_drive(4'b0000);
        check("0000_y_hi", {2'b0, y_hi}, 4'h0);
        check("0000_v_hi", {3'b0, v_hi}, 4'h0);
        check("0000_v_lo", {3'b0, v_lo}, 4'h0);
        step_edge();
        check("0000_yq_hi",  {2'b0, yq_hi},  4'h0);
        check("0000_vq_hi",  {3'b0, vq_hi},  4'h0);
        check("0000_chg_hi", {3'b0, chg_hi}, 4'h0);

        // 0001
        step_drive(4'b0001);
        check("0001_y_hi", {2'b0, y_hi}, 4'h0);
        check("0001_v_hi", {3'b0, v_hi}, 4'h1);
        check("0001_y_lo", {2'b0, y_lo}, 4'h0);
        step_edge();
        check("0001_yq_hi",  {2'b0, yq_hi},  4'h0);
        check("0001_vq_hi",  {3'b0, vq_hi},  4'h1);
        check("0001_chg_hi", {3'b0, chg_hi}, 4'h1);
        check("0001_chg_lo", {3'b0, chg_lo}, 4'h1);
        step_edge();
        check("0001_chg_hold", {3'b0, chg_hi}, 4'h0);
        check("0001_m_single", {3'b0, m_hi},   4'h0);

        // 0011 then 0110
        step_drive(4'b0011);
        check("0011_y_hi", {2'b0, y_hi}, 4'h1);
        check("0011_y_lo", {2'b0, y_lo}, 4'h0);
        check("0011_v_hi", {3'b0, v_hi}, 4'h1);
        step_edge();
        check("0011_yq_hi", {2'b0, yq_hi}, 4'h1);
        check("0011_m_hi",  {3'b0, m_hi},  {3'b0, MH_EN});
        check("0011_m_lo",  {3'b0, m_lo},  {3'b0, MH_EN});
        step_drive(4'b0110);
        check("0110_y_hi", {2'b0, y_hi}, 4'h2);
        check("0110_y_lo", {2'b0, y_lo}, 4'h1);
        step_edge();
        check("0110_yq_hi", {2'b0, yq_hi}, 4'h2);
        check("0110_yq_lo", {2'b0, yq_lo}, 4'h1);

        // 1001 held for three edges
        step_drive(4'b1001);
        check("1001_y_hi", {2'b0, y_hi}, 4'h3);
        check("1001_y_lo", {2'b0, y_lo}, 4'h0);
        step_edge();
        check("1001_chg1_hi", {3'b0, chg_hi}, 4'h1);
        check("1001_chg1_lo", {3'b0, chg_lo}, 4'h1);
        check("1001_yq_hi",   {2'b0, yq_hi},  4'h3);
        step_edge();
        check("1001_chg2_hi", {3'b0, chg_hi}, 4'h0);
        step_edge();
        check("1001_chg3_hi", {3'b0, chg_hi}, 4'h0);
        check("1001_chg3_lo", {3'b0, chg_lo}, 4'h0);

        // Asynchronous reset mid-cycle
        #2;
        rst = 1'b1;
        #1;
        check("arst_yq_hi",  {2'b0, yq_hi},  4'h0);
        check("arst_vq_hi",  {3'b0, vq_hi},  4'h0);
        check("arst_chg_hi", {3'b0, chg_hi}, 4'h0);
        check("arst_m_hi",   {3'b0, m_hi},   4'h0);
        check("arst_yq_lo",  {2'b0, yq_lo},  4'h0);
        check("arst_y_hi",   {2'b0, y_hi},   4'h3);
        check("arst_v_hi",   {3'b0, v_hi},   4'h1);
        @(negedge clk);
        d = 4'b0000;
        rst = 1'b0;

        // Exhaustive sweep, registered path checked one edge later
        prev_hi = 3'b000;
        prev_lo = 3'b000;
        sticky  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step_drive(i[3:0]);
            check($sformatf("sw%0d_y_hi", i), {2'b0, y_hi}, {2'b0, exp_hi[i]});
            check($sformatf("sw%0d_y_lo", i), {2'b0, y_lo}, {2'b0, exp_lo[i]});
            check($sformatf("sw%0d_v", i),    {2'b0, v_lo, v_hi}, {2'b0, {2{i != 0}}});
            cur_hi = {i != 0, exp_hi[i]};
            cur_lo = {i != 0, exp_lo[i]};
            sticky = sticky | exp_multi[i];
            step_edge();
            check($sformatf("sw%0d_q_hi", i),   {1'b0, vq_hi, yq_hi}, {1'b0, cur_hi});
            check($sformatf("sw%0d_q_lo", i),   {1'b0, vq_lo, yq_lo}, {1'b0, cur_lo});
            check($sformatf("sw%0d_chg_hi", i), {3'b0, chg_hi}, {3'b0, cur_hi != prev_hi});
            check($sformatf("sw%0d_chg_lo", i), {3'b0, chg_lo}, {3'b0, cur_lo != prev_lo});
            check($sformatf("sw%0d_m", i),      {3'b0, m_hi},   {3'b0, sticky & MH_EN});
            prev_hi = cur_hi;
            prev_lo = cur_lo;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
